acc_delta_reader: RTL and testbench
===================================

# acc_delta_reader

Reader-side companion to the accumulator datapath: requests the accumulator's output register via its `read` strobe, samples the registered running sum, and recovers the per-update increment as the modular difference from the previous sample. Emits each increment on a valid/ready handshake toward downstream display or logging logic. Sits on the accumulator's output port, in the same clock domain.

## Interface
- `Word_Length`, 8: width of the sum and delta words.
- `Settle_Cycles`, 1: cycles waited after the `read` pulse before sampling `sum_in`. Minimum 1.
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: reset; asynchronous, active-low.
- `start` in 1: request one sample; level, sampled only in IDLE.
- `sum_in` in Word_Length: accumulator registered output.
- `read` out 1: one-cycle strobe to the accumulator output register; registered.
- `delta_out` out Word_Length: recovered increment; stable while `delta_valid`.
- `delta_valid` out 1: delta available.
- `delta_ready` in 1: consumer accepts the delta.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, WAIT, PRESENT. Encoding is a 2-bit enum.
- IDLE: if `start`=1, go to READ; otherwise stay.
- READ: `read`=1 for exactly this cycle; go to WAIT and load the settle counter with Settle_Cycles-1.
- WAIT: when the counter is 0, capture `sum_in`.
  - Compute `delta = sum_in - prev` modulo 2^Word_Length (wrap, no saturation, no sign extension).
  - Update `prev <= sum_in` and go to PRESENT.
  - Otherwise decrement the counter.
- PRESENT: `delta_valid`=1 with `delta_out` held. When `delta_ready`=1, go to IDLE.
- `prev` resets to 0, matching the accumulator reset value, so the first delta equals the first sum.
- `start` outside IDLE is ignored. Requests are not queued.
- `delta_ready` while `delta_valid`=0 has no effect.
- `busy` is decoded combinationally from the state register.
- The block never writes the accumulator. Only `read` is driven toward it.

## Timing
- Reset values: `read`=0, `delta_valid`=0, `delta_out`=0, `busy`=0. Internally, state=IDLE, prev=0, counter=0.
- `n_rst` asserted at any point (including mid-WAIT or mid-PRESENT) forces these values immediately. A pending delta is discarded. After release, operation resumes from IDLE.
- With `start` high in cycle 0:
  - `read`=1 in cycle 1.
  - `sum_in` is valid from cycle 2.
  - Capture occurs at the end of cycle 1+Settle_Cycles.
  - `delta_valid`=1 from cycle 2+Settle_Cycles. Latency is Settle_Cycles+2 clocks.
- Transfer occurs on a rising edge with `delta_valid` and `delta_ready` both 1. `delta_valid` is 0 in the next cycle.
- Back-to-back: with `start` and `delta_ready` held high, one delta is produced every Settle_Cycles+3 cycles.

## Configuration
- `ACC_DELTA_ZSUP_EN` defined (zero suppression):
  - A captured delta of 0 skips PRESENT. The FSM goes WAIT→IDLE and `delta_valid` is never asserted.
  - `prev` is still updated.
- Not defined: every capture, including zero deltas, passes through PRESENT.

## Structure
- Shared package `acc_pkg`:
  - state enum typedef `acc_rd_state_t`.
  - default `Word_Length` constant, shared with the accumulator.
- Sub-module `acc_settle_timer`:
  - loadable down-counter, width `$clog2(Settle_Cycles+1)`.
  - ports: load, value, zero flag; same clock and reset.
- The FSM, the `prev` register and the subtractor live in the top module.

## Test plan
All cases use Word_Length=8 and Settle_Cycles=1.

- Reset: hold `n_rst`=0 for 3 cycles → `read`=0, `delta_valid`=0, `delta_out`=0x00, `busy`=0; release leaves the block idle.
- First sample: `start` pulse, `sum_in`=0x05 → `read` high exactly in cycle 1; `delta_out`=0x05 with `delta_valid` high from cycle 3.
- Second sample:
  - `sum_in`=0x0C → delta 0x07.
  - Then `sum_in`=0xFA → delta 0xEE.
  - Then `sum_in`=0x03 (wrap) → delta 0x09.
- Backpressure:
  - Hold `delta_ready`=0 for 4 cycles in PRESENT, pulsing `start` during this time → `delta_out` is held, no extra `read` pulse.
  - Then set `delta_ready`=1 → `delta_valid` is 0 next cycle and `busy` is 0.
- Reset mid-operation: assert `n_rst` in WAIT → outputs are 0 immediately; the next sample with `sum_in`=0x10 yields delta 0x10.
- Zero delta: repeat a sample with `sum_in` unchanged at 0x10 → delta 0x00 presented without `ACC_DELTA_ZSUP_EN`; no `delta_valid` and return to IDLE with it.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared accumulator word width and reader FSM state type.
package acc_pkg;
  localparam int WORD_LENGTH = 8;
  typedef enum logic [1:0] {IDLE, READ, WAIT, PRESENT} acc_rd_state_t;
endpackage

// File: rtl/acc_settle_timer.sv
// acc_settle_timer: loadable down-counter that stops at zero and flags it.
module acc_settle_timer #(
  parameter int Settle_Cycles = 1
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   load,
  input  logic [$clog2(Settle_Cycles+1)-1:0]     value,
  output logic                                   zero
);
  logic [$clog2(Settle_Cycles+1)-1:0] count;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/acc_delta_reader.sv
// acc_delta_reader: strobes the accumulator read, samples the sum and presents the modular increment.
// Define ACC_DELTA_ZSUP_EN to drop zero deltas without presenting them.
module acc_delta_reader
  import acc_pkg::*;
#(
  parameter int Word_Length   = WORD_LENGTH,
  parameter int Settle_Cycles = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic [Word_Length-1:0] sum_in,
  output logic                   read,
  output logic [Word_Length-1:0] delta_out,
  output logic                   delta_valid,
  input  logic                   delta_ready,
  output logic                   busy
);
  localparam int CW = $clog2(Settle_Cycles+1);
  localparam logic [CW-1:0] LOAD_VALUE = CW'(Settle_Cycles-1);
  acc_rd_state_t state;
  logic [Word_Length-1:0] prev, diff;
  logic settled;
  assign diff = sum_in - prev;
  assign busy = state != IDLE;
  acc_settle_timer #(.Settle_Cycles(Settle_Cycles)) u_timer (
    .clk(clk), .n_rst(n_rst), .load(state == READ), .value(LOAD_VALUE), .zero(settled)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state       <= IDLE;
      prev        <= '0;
      delta_out   <= '0;
      delta_valid <= 1'b0;
      read        <= 1'b0;
    end else begin
      read <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= READ;
          read  <= 1'b1;
        end
        READ: state <= WAIT;
        WAIT: if (settled) begin
          delta_out <= diff;
          prev      <= sum_in;
`ifdef ACC_DELTA_ZSUP_EN
          state       <= (diff == '0) ? IDLE : PRESENT;
          delta_valid <= diff != '0;
`else
          state       <= PRESENT;
          delta_valid <= 1'b1;
`endif
        end
        PRESENT: if (delta_ready) begin
          state       <= IDLE;
          delta_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_acc_delta_reader.sv
// tb_acc_delta_reader: directed vectors for acc_delta_reader (Word_Length=8, Settle_Cycles=1).
module tb_acc_delta_reader;
  logic clk = 0, n_rst = 0, start = 0, read, delta_valid, delta_ready = 0, busy;
  logic [7:0] sum_in = 0, delta_out;
  int errors = 0, checks = 0;
  acc_delta_reader #(.Word_Length(8), .Settle_Cycles(1)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .sum_in(sum_in), .read(read),
    .delta_out(delta_out), .delta_valid(delta_valid), .delta_ready(delta_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic sample(input logic [7:0] s, input logic [7:0] e, input string tag);
    int n = 0;
    sum_in = s;
    start = 1;
    tick();
    start = 0;
    while (!delta_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, " valid"}, delta_valid, 1);
    check({tag, " delta"}, delta_out, e);
    delta_ready = 1;
    tick();
    delta_ready = 0;
    check({tag, " drop"}, delta_valid, 0);
  endtask
  initial begin
    int reads, seen;
    repeat (3) tick();
    check("rst read", read, 0);
    check("rst valid", delta_valid, 0);
    check("rst delta", delta_out, 8'h00);
    check("rst busy", busy, 0);
    n_rst = 1;
    tick();
    check("idle busy", busy, 0);
    check("idle read", read, 0);
    // first sample, cycle-exact
    sum_in = 8'h05;
    start = 1;
    tick();
    start = 0;
    check("c1 read", read, 1);
    check("c1 busy", busy, 1);
    tick();
    check("c2 read", read, 0);
    check("c2 valid", delta_valid, 0);
    tick();
    check("c3 valid", delta_valid, 1);
    check("c3 delta", delta_out, 8'h05);
    delta_ready = 1;
    tick();
    delta_ready = 0;
    check("c4 valid", delta_valid, 0);
    check("c4 busy", busy, 0);
    sample(8'h0C, 8'h07, "s2");
    sample(8'hFA, 8'hEE, "s3");
    sample(8'h03, 8'h09, "wrap");
    // backpressure with start pulses while presenting
    sum_in = 8'h20;
    start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    check("bp valid", delta_valid, 1);
    reads = 0;
    for (int i = 0; i < 4; i++) begin
      start = i[0];
      tick();
      reads += int'(read);
      check("bp hold", delta_out, 8'h1D);
      check("bp valid hold", delta_valid, 1);
    end
    start = 0;
    check("bp reads", reads, 0);
    delta_ready = 1;
    tick();
    delta_ready = 0;
    check("bp done valid", delta_valid, 0);
    check("bp done busy", busy, 0);
    // reset during WAIT
    sum_in = 8'h10;
    start = 1;
    tick();
    start = 0;
    tick();
    n_rst = 0;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst delta", delta_out, 8'h00);
    check("mid rst valid", delta_valid, 0);
    check("mid rst read", read, 0);
    tick();
    n_rst = 1;
    tick();
    sample(8'h10, 8'h10, "post rst");
`ifdef ACC_DELTA_ZSUP_EN
    sum_in = 8'h10;
    start = 1;
    tick();
    start = 0;
    seen = 0;
    repeat (6) begin
      tick();
      seen += int'(delta_valid);
    end
    check("zsup valid", seen, 0);
    check("zsup busy", busy, 0);
`else
    seen = 0;
    sample(8'h10, 8'h00, "zero");
    check("zero busy", busy, seen);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
